// File: rtl/eth_pkg.sv
// eth_pkg: state encoding and Ethernet framing/CRC constants shared by the
// MAC transmit path and the future receive path.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/mac_tx_if.sv
// mac_tx_if: host-to-MAC byte stream (valid/ready with end-of-frame marker).
interface mac_tx_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    // Host side drives bytes, MAC side returns ready.
    modport master (output in_valid, output in_data, output in_last, input  out_ready);
    modport slave  (input  in_valid, input  in_data, input  in_last, output out_ready);

endinterface

// File: rtl/crc32_d8.sv
// crc32_d8: one-byte step of the reflected Ethernet CRC-32 (LSB first).
// Purely combinational; the caller owns the CRC register.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Shift the eight data bits through the LFSR, LSB first.
    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/mac_tx.sv
// mac_tx: Ethernet MAC transmitter. Frames host bytes with preamble/SFD,
// pads to the minimum length, appends the CRC-32 FCS and holds the
// inter-frame gap. Underrun or oversize aborts the frame with txer.
module mac_tx
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter int unsigned MIN_PAYLOAD    = 60,
    parameter int unsigned MAX_PAYLOAD    = 1514,
    parameter int unsigned IFG_BYTES      = 12
) (
    input  logic       in_clk,
    input  logic       in_rst,
    mac_tx_if.slave    host,
    output logic       out_txen,
    output logic [7:0] out_txd,
    output logic       out_txer,
    output logic       out_busy
);

    localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
    localparam logic [7:0]  FCS_LAST = 8'd3;

    tx_state_t   state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  aux_q, aux_d;
    logic [31:0] crc_q, crc_d, crc_upd;
    logic [7:0]  crc_din;
    logic [10:0] cnt_inc;
    logic        in_frame;
    logic        abort;
    logic [31:0] fcs;
    logic        txen_d, txer_d;
    logic [7:0]  txd_d;

    // Note: the wire outputs are registered, so each state chooses what the
    // wire carries in the *next* cycle. IDLE therefore emits the first
    // preamble byte and the last PREAMBLE cycle emits the SFD, which puts the
    // SFD on the wire in the same cycle the FSM sits in SFD and raises ready.

    assign cnt_inc  = cnt_q + 11'd1;
    assign in_frame = (state_q == ST_SFD) || (state_q == ST_DATA);
    // Abort on a missing byte, or on any byte once MAX_PAYLOAD bytes went
    // out without in_last; that byte is dropped.
    assign abort    = in_frame && (!host.in_valid || (cnt_q == MAX_P));
    assign crc_din  = (state_q == ST_PAD) ? 8'h00 : host.in_data;
    assign fcs      = ~crc_q;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (crc_din),
        .crc_out (crc_upd)
    );

    // State, byte counter, phase counter and running CRC.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            aux_q   <= '0;
            crc_q   <= CRC_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            aux_q   <= aux_d;
            crc_q   <= crc_d;
        end
    end

    // Registered PHY outputs and busy flag.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_txen <= 1'b0;
            out_txer <= 1'b0;
            out_txd  <= '0;
            out_busy <= 1'b0;
        end else begin
            out_txen <= txen_d;
            out_txer <= txer_d;
            out_txd  <= txd_d;
            out_busy <= (state_d != ST_IDLE);
        end
    end

    // Next-state, counter and CRC update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        aux_d   = aux_q;
        crc_d   = crc_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                aux_d = '0;
                crc_d = CRC_INIT;
                if (host.in_valid) begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (aux_q == PRE_LAST) begin
                    aux_d   = '0;
                    state_d = ST_SFD;
                end else begin
                    aux_d = aux_q + 8'd1;
                end
            end
            ST_SFD, ST_DATA: begin
                aux_d = '0;
                if (abort) begin
                    state_d = (host.in_valid && host.in_last) ? ST_IFG : ST_DRAIN;
                end else begin
                    crc_d = crc_upd;
                    cnt_d = cnt_inc;
                    if (host.in_last) begin
                        state_d = (cnt_inc < MIN_P) ? ST_PAD : ST_FCS;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_PAD: begin
                crc_d = crc_upd;
                cnt_d = cnt_inc;
                if (cnt_inc == MIN_P) begin
                    state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                if (aux_q == FCS_LAST) begin
                    aux_d   = '0;
                    state_d = ST_IFG;
                end else begin
                    aux_d = aux_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                aux_d = '0;
                if (host.in_valid && host.in_last) begin
                    state_d = ST_IFG;
                end
            end
            ST_IFG: begin
                if (aux_q == IFG_LAST) begin
                    aux_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    aux_d = aux_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Host ready decode and next wire byte selection.
    always_comb begin
        host.out_ready = (state_q == ST_SFD) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
        txen_d = 1'b0;
        txer_d = 1'b0;
        txd_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (host.in_valid) begin
                    txen_d = 1'b1;
                    txd_d  = PREAMBLE_BYTE;
                end
            end
            ST_PREAMBLE: begin
                txen_d = 1'b1;
                txd_d  = (aux_q == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
            end
            ST_SFD, ST_DATA: begin
                txen_d = 1'b1;
                if (abort) begin
                    txer_d = 1'b1;
                end else begin
                    txd_d = host.in_data;
                end
            end
            ST_PAD: begin
                txen_d = 1'b1;
            end
            ST_FCS: begin
                txen_d = 1'b1;
                case (aux_q[1:0])
                    2'd0:    txd_d = fcs[7:0];
                    2'd1:    txd_d = fcs[15:8];
                    2'd2:    txd_d = fcs[23:16];
                    default: txd_d = fcs[31:24];
                endcase
            end
            default: begin
                txen_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_tx.sv
// tb_mac_tx: directed and randomized frames through two mac_tx instances
// (default padding and MIN_PAYLOAD=0); the wire is captured every cycle and
// compared against a table-driven framing/CRC model.
module tb_mac_tx;

    localparam int unsigned IFG    = 12;
    localparam int unsigned MINP   = 60;
    localparam int unsigned MAXP   = 1514;
    localparam int unsigned NOHOLE = 32'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel;
    logic       h_valid, h_last;
    logic [7:0] h_data;

    logic       txen_a, txer_a, busy_a;
    logic [7:0] txd_a;
    logic       txen_b, txer_b, busy_b;
    logic [7:0] txd_b;
    logic       m_txen, m_txer, m_busy, m_ready;
    logic [7:0] m_txd;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [9:0]  cap[$];
    logic [9:0]  exp_q[$];
    logic [31:0] crc_tbl[256];
    logic [7:0]  fa[$], f1[$], f2[$];
    int unsigned s, a, g, n, guard;
    bit          acc;

    always #5 clk = ~clk;

    mac_tx_if ifa ();
    mac_tx_if ifb ();

    assign ifa.in_valid = h_valid & ~sel;
    assign ifa.in_data  = h_data;
    assign ifa.in_last  = h_last;
    assign ifb.in_valid = h_valid & sel;
    assign ifb.in_data  = h_data;
    assign ifb.in_last  = h_last;

    mac_tx #(.PREAMBLE_BYTES(7), .MIN_PAYLOAD(60), .MAX_PAYLOAD(1514), .IFG_BYTES(12)) dut_a (
        .in_clk(clk), .in_rst(rst), .host(ifa),
        .out_txen(txen_a), .out_txd(txd_a), .out_txer(txer_a), .out_busy(busy_a)
    );

    mac_tx #(.PREAMBLE_BYTES(7), .MIN_PAYLOAD(0), .MAX_PAYLOAD(1514), .IFG_BYTES(12)) dut_b (
        .in_clk(clk), .in_rst(rst), .host(ifb),
        .out_txen(txen_b), .out_txd(txd_b), .out_txer(txer_b), .out_busy(busy_b)
    );

    assign m_txen  = sel ? txen_b : txen_a;
    assign m_txer  = sel ? txer_b : txer_a;
    assign m_txd   = sel ? txd_b  : txd_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_ready = sel ? ifb.out_ready : ifa.out_ready;

    // Wire monitor: one {txen, txer, txd} sample per cycle, away from the edge.
    always @(negedge clk) cap.push_back({m_txen, m_txer, m_txd});

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void init_tbl();
        logic [31:0] r;
        for (int unsigned k = 0; k < 256; k++) begin
            r = k;
            for (int unsigned b = 0; b < 8; b++) begin
                r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
            end
            crc_tbl[k] = r;
        end
    endfunction

    task automatic make_frame(input int unsigned len);
        fa.delete();
        repeat (len) fa.push_back(8'($urandom));
    endtask

    // Model: what the wire must carry while txen is high.
    function automatic void build_exp(input logic [7:0] fr[$], input int unsigned minp,
                                      input int unsigned n_sent, input bit aborted);
        logic [7:0]  pay[$];
        logic [31:0] c;
        exp_q.delete();
        repeat (7) exp_q.push_back({2'b10, 8'h55});
        exp_q.push_back({2'b10, 8'hD5});
        if (aborted) begin
            for (int unsigned k = 0; k < n_sent; k++) exp_q.push_back({2'b10, fr[k]});
            exp_q.push_back({2'b11, 8'h00});
            return;
        end
        pay = fr;
        while (pay.size() < minp) pay.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (pay[k]) c = (c >> 8) ^ crc_tbl[c[7:0] ^ pay[k]];
        foreach (pay[k]) exp_q.push_back({2'b10, pay[k]});
        c = ~c;
        for (int unsigned k = 0; k < 4; k++) begin
            exp_q.push_back({2'b10, c[7:0]});
            c = c >> 8;
        end
    endfunction

    function automatic int unsigned count_txen();
        int unsigned c = 0;
        foreach (cap[k]) if (cap[k][9] === 1'b1) c++;
        return c;
    endfunction

    task automatic drive_frame(input logic [7:0] fr[$], input int unsigned hole, input bit hold_after);
        int unsigned i = 0;
        int unsigned gd = 0;
        bit hole_done = 0;
        bit ac;
        @(posedge clk); #1;
        while (i < fr.size() && gd < 4000) begin
            h_valid = !(i == hole && !hole_done);
            h_data  = fr[i];
            h_last  = (i == fr.size() - 1);
            @(negedge clk);
            ac = h_valid && m_ready;
            if (!h_valid && m_ready) hole_done = 1;
            @(posedge clk); #1;
            if (ac) i++;
            gd++;
        end
        h_valid = hold_after;
        h_last  = 1'b0;
        chk("drive_done", i, fr.size());
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k = 0;
        @(negedge clk);
        while (m_busy && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, 32'(m_busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int unsigned from,
                               output int unsigned start, output int unsigned after,
                               output int unsigned gap);
        int unsigned j = from;
        logic [9:0] obs;
        while (j < cap.size() && cap[j][9] !== 1'b1) j++;
        start = j;
        for (int unsigned k = 0; k < exp_q.size(); k++) begin
            obs = (j + k < cap.size()) ? cap[j + k] : 10'h3FF;
            chk($sformatf("%s[%0d]", tag, k), 32'(obs), 32'(exp_q[k]));
            if (obs !== exp_q[k]) break;
        end
        j += exp_q.size();
        gap = 0;
        while (j < cap.size() && cap[j][9] === 1'b0) begin
            gap++;
            j++;
        end
        after = j;
    endtask

    function automatic logic [7:0] cap_byte(input int unsigned idx);
        return (idx < cap.size()) ? cap[idx][7:0] : 8'hXX;
    endfunction

    initial begin
        init_tbl();
        sel = 1'b0; h_valid = 1'b0; h_last = 1'b0; h_data = 8'h00;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txen_a",  32'(txen_a), 0);
        chk("rst_txer_a",  32'(txer_a), 0);
        chk("rst_txd_a",   32'(txd_a), 0);
        chk("rst_ready_a", 32'(ifa.out_ready), 0);
        chk("rst_busy_a",  32'(busy_a), 0);
        chk("rst_txen_b",  32'(txen_b), 0);
        chk("rst_busy_b",  32'(busy_b), 0);
        @(negedge clk) rst = 1'b0;

        // "123456789" with padding disabled: known FCS bytes.
        sel = 1'b1;
        fa.delete();
        for (int unsigned k = 0; k < 9; k++) fa.push_back(8'h31 + 8'(k));
        cap.delete();
        drive_frame(fa, NOHOLE, 0);
        wait_idle("check9");
        build_exp(fa, 0, 0, 0);
        check_frame("check9", 0, s, a, g);
        chk("check9_fcs0", 32'(cap_byte(s + 17)), 32'h26);
        chk("check9_fcs1", 32'(cap_byte(s + 18)), 32'h39);
        chk("check9_fcs2", 32'(cap_byte(s + 19)), 32'hF4);
        chk("check9_fcs3", 32'(cap_byte(s + 20)), 32'hCB);
        chk("check9_ifg",  32'(g >= IFG), 1);

        // Single byte: padded to 60, txen high for 72 cycles.
        sel = 1'b0;
        fa.delete();
        fa.push_back(8'hAB);
        cap.delete();
        drive_frame(fa, NOHOLE, 0);
        wait_idle("one");
        build_exp(fa, MINP, 0, 0);
        check_frame("one", 0, s, a, g);
        chk("one_txen_cycles", count_txen(), 72);
        chk("one_ifg", 32'(g >= IFG), 1);

        // Exactly minimum and one over minimum: no padding.
        make_frame(60);
        cap.delete();
        drive_frame(fa, NOHOLE, 0);
        wait_idle("len60");
        build_exp(fa, MINP, 0, 0);
        check_frame("len60", 0, s, a, g);
        chk("len60_txen_cycles", count_txen(), 72);

        make_frame(61);
        cap.delete();
        drive_frame(fa, NOHOLE, 0);
        wait_idle("len61");
        build_exp(fa, MINP, 0, 0);
        check_frame("len61", 0, s, a, g);
        chk("len61_txen_cycles", count_txen(), 73);

        // Underrun at data byte 20, remaining bytes drained.
        make_frame(30);
        cap.delete();
        drive_frame(fa, 19, 0);
        wait_idle("underrun");
        build_exp(fa, MINP, 19, 1);
        check_frame("underrun", 0, s, a, g);
        chk("underrun_txen_cycles", count_txen(), 28);
        chk("underrun_ifg", 32'(g >= IFG), 1);

        // Oversize: byte 1515 aborts and is not sent.
        make_frame(MAXP + 1);
        cap.delete();
        drive_frame(fa, NOHOLE, 0);
        wait_idle("oversize");
        build_exp(fa, MINP, MAXP, 1);
        check_frame("oversize", 0, s, a, g);
        chk("oversize_txen_cycles", count_txen(), 8 + MAXP + 1);

        // Back-to-back with in_valid held through the gap.
        make_frame(20); f1 = fa;
        make_frame(70); f2 = fa;
        cap.delete();
        drive_frame(f1, NOHOLE, 1);
        drive_frame(f2, NOHOLE, 0);
        wait_idle("b2b");
        build_exp(f1, MINP, 0, 0);
        check_frame("b2b_first", 0, s, a, g);
        chk("b2b_gap", g, IFG);
        build_exp(f2, MINP, 0, 0);
        check_frame("b2b_second", a, s, a, g);

        // Reset in the middle of DATA, then a clean frame.
        make_frame(30);
        cap.delete();
        @(posedge clk); #1;
        h_valid = 1'b1; h_last = 1'b0; h_data = fa[0];
        n = 0; guard = 0;
        while (n < 10 && guard < 100) begin
            @(negedge clk);
            acc = m_ready;
            @(posedge clk); #1;
            if (acc) begin
                n++;
                h_data = fa[n];
            end
            guard++;
        end
        chk("rstmid_reached", n, 10);
        chk("rstmid_pre_txen", 32'(m_txen), 1);
        #3 rst = 1'b1;
        #1;
        chk("rstmid_txen",  32'(m_txen), 0);
        chk("rstmid_txer",  32'(m_txer), 0);
        chk("rstmid_ready", 32'(m_ready), 0);
        chk("rstmid_busy",  32'(m_busy), 0);
        h_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        make_frame(45);
        cap.delete();
        drive_frame(fa, NOHOLE, 0);
        wait_idle("after_rst");
        build_exp(fa, MINP, 0, 0);
        check_frame("after_rst", 0, s, a, g);

        // Random lengths on either instance.
        for (int unsigned r = 0; r < 4; r++) begin
            sel = 1'($urandom_range(0, 1));
            make_frame($urandom_range(1, 90));
            cap.delete();
            drive_frame(fa, NOHOLE, 0);
            wait_idle($sformatf("rand%0d", r));
            build_exp(fa, sel ? 0 : MINP, 0, 0);
            check_frame($sformatf("rand%0d", r), 0, s, a, g);
            chk($sformatf("rand%0d_ifg", r), 32'(g >= IFG), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
